// File: rtl/lcd_cmd_decoder_if.sv
// ============================================================================
// Module      : lcd_cmd_decoder_if
// Description : Byte-stream input and pixel/state outputs of lcd_cmd_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_cmd_decoder_if;
    logic        wr_valid;
    logic [7:0]  D;
    logic        dcx;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_color;
    logic        disp_on;
    logic        sleep_out;
    logic [15:0] win_sc;
    logic [15:0] win_ec;
    logic [15:0] win_sp;
    logic [15:0] win_ep;
    logic        err;

    modport slave (
        input  wr_valid, D, dcx,
        output pix_valid, pix_x, pix_y, pix_color, disp_on, sleep_out,
               win_sc, win_ec, win_sp, win_ep, err
    );

    modport master (
        output wr_valid, D, dcx,
        input  pix_valid, pix_x, pix_y, pix_color, disp_on, sleep_out,
               win_sc, win_ec, win_sp, win_ep, err
    );
endinterface

`default_nettype wire

// File: rtl/lcd_cmd_decoder.sv
// ============================================================================
// Module      : lcd_cmd_decoder
// Description : Decodes the LCD command/data byte stream into window/state
//               registers and addressed RGB565 pixel writes.
//               Optional sticky error flag: define LCD_DEC_ERR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_cmd_decoder #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  wire logic          clk,
    input  wire logic          nrst,
    lcd_cmd_decoder_if.slave   bus
);

    localparam logic [15:0] c_EC_RST = 16'(WIDTH - 1);
    localparam logic [15:0] c_EP_RST = 16'(HEIGHT - 1);

    localparam logic [7:0] c_CMD_SWRESET = 8'h01;
    localparam logic [7:0] c_CMD_SLPIN   = 8'h10;
    localparam logic [7:0] c_CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] c_CMD_DISPOFF = 8'h28;
    localparam logic [7:0] c_CMD_DISPON  = 8'h29;
    localparam logic [7:0] c_CMD_CASET   = 8'h2A;
    localparam logic [7:0] c_CMD_PASET   = 8'h2B;
    localparam logic [7:0] c_CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CA_P   = 3'd1,
        S_PA_P   = 3'd2,
        S_RAM_LO = 3'd3,
        S_RAM_HI = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [23:0] r_shadow, w_shadow_nxt;
    logic [15:0] r_sc, r_ec, r_sp, r_ep;
    logic [15:0] w_sc_nxt, w_ec_nxt, w_sp_nxt, w_ep_nxt;
    logic [15:0] r_cx, r_cy, w_cx_nxt, w_cy_nxt;
    logic [7:0]  r_lo, w_lo_nxt;
    logic        r_pv, w_pv_nxt;
    logic [15:0] r_px, r_py, r_pc, w_px_nxt, w_py_nxt, w_pc_nxt;
    logic        r_disp, w_disp_nxt;
    logic        r_sleep, w_sleep_nxt;
    logic [15:0] w_start, w_end;
`ifdef LCD_DEC_ERR_CHECK_EN
    logic        r_err, w_err_nxt;
`endif

    // The 4th parameter byte is taken straight from the bus so start and end
    // commit together on that edge.
    assign w_start = r_shadow[23:8];
    assign w_end   = {r_shadow[7:0], bus.D};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_shadow <= 24'd0;
            r_sc     <= 16'd0;
            r_ec     <= c_EC_RST;
            r_sp     <= 16'd0;
            r_ep     <= c_EP_RST;
            r_cx     <= 16'd0;
            r_cy     <= 16'd0;
            r_lo     <= 8'd0;
            r_pv     <= 1'b0;
            r_px     <= 16'd0;
            r_py     <= 16'd0;
            r_pc     <= 16'd0;
            r_disp   <= 1'b0;
            r_sleep  <= 1'b0;
`ifdef LCD_DEC_ERR_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
            r_sc     <= w_sc_nxt;
            r_ec     <= w_ec_nxt;
            r_sp     <= w_sp_nxt;
            r_ep     <= w_ep_nxt;
            r_cx     <= w_cx_nxt;
            r_cy     <= w_cy_nxt;
            r_lo     <= w_lo_nxt;
            r_pv     <= w_pv_nxt;
            r_px     <= w_px_nxt;
            r_py     <= w_py_nxt;
            r_pc     <= w_pc_nxt;
            r_disp   <= w_disp_nxt;
            r_sleep  <= w_sleep_nxt;
`ifdef LCD_DEC_ERR_CHECK_EN
            r_err    <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_shadow_nxt = r_shadow;
        w_sc_nxt     = r_sc;
        w_ec_nxt     = r_ec;
        w_sp_nxt     = r_sp;
        w_ep_nxt     = r_ep;
        w_cx_nxt     = r_cx;
        w_cy_nxt     = r_cy;
        w_lo_nxt     = r_lo;
        w_pv_nxt     = 1'b0;
        w_px_nxt     = r_px;
        w_py_nxt     = r_py;
        w_pc_nxt     = r_pc;
        w_disp_nxt   = r_disp;
        w_sleep_nxt  = r_sleep;
`ifdef LCD_DEC_ERR_CHECK_EN
        w_err_nxt    = r_err;
`endif
        if (bus.wr_valid && !bus.dcx) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 2'd0;
            case (bus.D)
                c_CMD_SWRESET: begin
                    w_shadow_nxt = 24'd0;
                    w_sc_nxt     = 16'd0;
                    w_ec_nxt     = c_EC_RST;
                    w_sp_nxt     = 16'd0;
                    w_ep_nxt     = c_EP_RST;
                    w_cx_nxt     = 16'd0;
                    w_cy_nxt     = 16'd0;
                    w_lo_nxt     = 8'd0;
                    w_px_nxt     = 16'd0;
                    w_py_nxt     = 16'd0;
                    w_pc_nxt     = 16'd0;
                    w_disp_nxt   = 1'b0;
                    w_sleep_nxt  = 1'b0;
`ifdef LCD_DEC_ERR_CHECK_EN
                    w_err_nxt    = 1'b0;
`endif
                end
                c_CMD_DISPOFF: w_disp_nxt  = 1'b0;
                c_CMD_DISPON:  w_disp_nxt  = 1'b1;
                c_CMD_SLPIN:   w_sleep_nxt = 1'b0;
                c_CMD_SLPOUT:  w_sleep_nxt = 1'b1;
                c_CMD_CASET:   w_state_nxt = S_CA_P;
                c_CMD_PASET:   w_state_nxt = S_PA_P;
                c_CMD_RAMWR: begin
                    w_state_nxt = S_RAM_LO;
                    w_cx_nxt    = r_sc;
                    w_cy_nxt    = r_sp;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (bus.wr_valid) begin
            case (r_state)
                S_CA_P, S_PA_P: begin
                    w_idx_nxt = r_idx + 2'd1;
                    case (r_idx)
                        2'd0: w_shadow_nxt[23:16] = bus.D;
                        2'd1: w_shadow_nxt[15:8]  = bus.D;
                        2'd2: w_shadow_nxt[7:0]   = bus.D;
                        default: begin
                            w_state_nxt = S_IDLE;
                            if (r_state == S_CA_P) begin
                                w_sc_nxt = w_start;
                                w_ec_nxt = w_end;
                            end else begin
                                w_sp_nxt = w_start;
                                w_ep_nxt = w_end;
                            end
`ifdef LCD_DEC_ERR_CHECK_EN
                            if ((w_start > w_end) ||
                                ((r_state == S_CA_P) && (w_end > c_EC_RST)) ||
                                ((r_state == S_PA_P) && (w_end > c_EP_RST)))
                                w_err_nxt = 1'b1;
`endif
                        end
                    endcase
                end
                S_RAM_LO: begin
                    w_lo_nxt    = bus.D;
                    w_state_nxt = S_RAM_HI;
                end
                S_RAM_HI: begin
                    w_pv_nxt    = 1'b1;
                    w_px_nxt    = r_cx;
                    w_py_nxt    = r_cy;
                    w_pc_nxt    = {bus.D, r_lo};
                    w_state_nxt = S_RAM_LO;
                    // Window ends are inclusive; row wraps back to window top.
                    if (r_cx == r_ec) begin
                        w_cx_nxt = r_sc;
                        w_cy_nxt = (r_cy == r_ep) ? r_sp : r_cy + 16'd1;
                    end else begin
                        w_cx_nxt = r_cx + 16'd1;
                    end
`ifdef LCD_DEC_ERR_CHECK_EN
                    if (!r_sleep)
                        w_err_nxt = 1'b1;
`endif
                end
                default: begin
`ifdef LCD_DEC_ERR_CHECK_EN
                    w_err_nxt = 1'b1;
`endif
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.pix_valid = r_pv;
    assign bus.pix_x     = r_px;
    assign bus.pix_y     = r_py;
    assign bus.pix_color = r_pc;
    assign bus.disp_on   = r_disp;
    assign bus.sleep_out = r_sleep;
    assign bus.win_sc    = r_sc;
    assign bus.win_ec    = r_ec;
    assign bus.win_sp    = r_sp;
    assign bus.win_ep    = r_ep;
`ifdef LCD_DEC_ERR_CHECK_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

`default_nettype wire
